// File: rtl/unit_test_seq_pkg.sv
// Shared types for the unit-test sequencer: FSM state encoding, vector table entry layout, default timeout.
// Table entries are sized from SEQ_WIDTH / SEQ_CHANNELS; keep those in step with the top-level WIDTH / CHANNELS.
package unit_test_seq_pkg;

    localparam int SEQ_WIDTH    = 32;
    localparam int SEQ_CHANNELS = 4;
    localparam int SEQ_CH_W     = (SEQ_CHANNELS > 1) ? $clog2(SEQ_CHANNELS) : 1;
    localparam int TIMEOUT_DEF  = 15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    typedef struct packed {
        logic [SEQ_CH_W-1:0]  chan;
        logic [SEQ_WIDTH-1:0] stim;
        logic [SEQ_WIDTH-1:0] exp;
    } vector_t;

endpackage

// File: rtl/unit_test_vec_ram.sv
// Vector table: DEPTH entries, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded table survives a mid-run reset.
module unit_test_vec_ram
    import unit_test_seq_pkg::*;
#(
    parameter int  DEPTH = 23,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  vector_t       wdata,
    input  logic [AW-1:0] raddr,
    output vector_t       rdata
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    vector_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH_L)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DEPTH_L) ? mem_q[raddr] : '0;

endmodule

// File: rtl/unit_test_sequencer.sv
// Vector-driven unit-test sequencer: issues table entries to DUT channels, compares responses, keeps stats.
// Define UNIT_TEST_SEQ_TIMEOUT_EN to bound each WAIT to TIMEOUT cycles (a silent DUT then scores a fail).
module unit_test_sequencer
    import unit_test_seq_pkg::*;
#(
    parameter int  WIDTH    = SEQ_WIDTH,
    parameter int  DEPTH    = 23,
    parameter int  CHANNELS = SEQ_CHANNELS,
    parameter int  TIMEOUT  = TIMEOUT_DEF,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NVW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_we,
    input  logic [AW-1:0]             load_addr,
    input  logic [CH_W-1:0]           load_chan,
    input  logic [WIDTH-1:0]          load_stim,
    input  logic [WIDTH-1:0]          load_exp,
    input  logic [NVW-1:0]            num_vec,
    input  logic                      stop_on_fail,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS-1:0]       dut_valid,
    output logic [WIDTH-1:0]          dut_stim,
    input  logic [CHANNELS-1:0]       dut_resp_valid,
    input  logic [CHANNELS*WIDTH-1:0] dut_resp,
    output logic [NVW-1:0]            pass_count,
    output logic [NVW-1:0]            fail_count,
    output logic [AW-1:0]             first_fail_idx,
    output logic                      fail_seen
);

    localparam logic [CHANNELS-1:0] ONE      = CHANNELS'(1);
    localparam logic [NVW-1:0]      DEPTH_NV = NVW'(DEPTH);

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         last_q, last_d;
    logic                  stop_q, stop_d;
    logic [CHANNELS-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]      exp_q, exp_d;
    logic                  match_q, match_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CHANNELS-1:0]   dut_valid_q, dut_valid_d;
    logic [WIDTH-1:0]      dut_stim_q, dut_stim_d;
    logic [NVW-1:0]        pass_q, pass_d;
    logic [NVW-1:0]        fail_q, fail_d;
    logic [AW-1:0]         ffi_q, ffi_d;
    logic                  seen_q, seen_d;

    logic                  ram_we;
    logic                  issue;
    logic [AW-1:0]         rd_addr;
    logic [NVW-1:0]        nv_clamp;
    logic [WIDTH-1:0]      resp_sel;
    vector_t               wr_vec, rd_vec;

`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
    localparam int            TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign wr_vec = '{chan: load_chan, stim: load_stim, exp: load_exp};
    // The only time we read ahead is when CHECK hands over to the next ISSUE (or IDLE starts at 0).
    assign rd_addr  = (state_q == S_CHECK) ? idx_q + AW'(1) : '0;
    assign nv_clamp = (num_vec > DEPTH_NV) ? DEPTH_NV : num_vec;

    unit_test_vec_ram #(.DEPTH(DEPTH)) u_vec_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (wr_vec),
        .raddr (rd_addr),
        .rdata (rd_vec)
    );

    always_comb begin
        resp_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_q[c]) resp_sel = dut_resp[c*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        stop_d      = stop_q;
        sel_d       = sel_q;
        exp_d       = exp_q;
        match_d     = match_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dut_valid_d = '0;
        dut_stim_d  = dut_stim_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        ffi_d       = ffi_q;
        seen_d      = seen_q;
        ram_we      = 1'b0;
        issue       = 1'b0;
`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                ram_we = load_we;
                if (start) begin
                    pass_d = '0;
                    fail_d = '0;
                    ffi_d  = '0;
                    seen_d = 1'b0;
                    busy_d = 1'b1;
                    if (num_vec == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        last_d = AW'(nv_clamp - NVW'(1));
                        stop_d = stop_on_fail;
                        idx_d  = '0;
                        issue  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
                tmo_d   = '0;
                state_d = S_WAIT;
`else
                // An out-of-range channel never strobes, so nothing could ever answer it.
                if (sel_q == '0) begin
                    match_d = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_WAIT: begin
                if (|(dut_resp_valid & sel_q)) begin
                    match_d = (resp_sel == exp_q);
                    state_d = S_CHECK;
                end
`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    match_d = 1'b0;
                    state_d = S_CHECK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_CHECK: begin
                if (match_q) begin
                    pass_d = pass_q + NVW'(1);
                end else begin
                    fail_d = fail_q + NVW'(1);
                    if (!seen_q) begin
                        seen_d = 1'b1;
                        ffi_d  = idx_q;
                    end
                end
                if ((idx_q == last_q) || (!match_q && stop_q)) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                    issue = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (issue) begin
            state_d     = S_ISSUE;
            sel_d       = ONE << rd_vec.chan;
            exp_d       = rd_vec.exp;
            dut_valid_d = ONE << rd_vec.chan;
            dut_stim_d  = rd_vec.stim;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            stop_q      <= 1'b0;
            sel_q       <= '0;
            exp_q       <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dut_valid_q <= '0;
            dut_stim_q  <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            ffi_q       <= '0;
            seen_q      <= 1'b0;
`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            stop_q      <= stop_d;
            sel_q       <= sel_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dut_valid_q <= dut_valid_d;
            dut_stim_q  <= dut_stim_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            ffi_q       <= ffi_d;
            seen_q      <= seen_d;
`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign dut_valid      = dut_valid_q;
    assign dut_stim       = dut_stim_q;
    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;
    assign fail_seen      = seen_q;

endmodule

// File: tb/tb_unit_test_sequencer.sv
// Bench for unit_test_sequencer: behavioural echo DUTs per channel, a table model, strobe/count scoreboard.
// Timeout scenario is exercised only when UNIT_TEST_SEQ_TIMEOUT_EN is defined.
module tb_unit_test_sequencer;

    localparam int WIDTH = 32, DEPTH = 23, CHANNELS = 4, TIMEOUT = 4;

    logic         clk = 1'b0, rst_n = 1'b1;
    logic         load_we = 1'b0;
    logic [4:0]   load_addr = '0;
    logic [1:0]   load_chan = '0;
    logic [31:0]  load_stim = '0, load_exp = '0;
    logic [4:0]   num_vec = '0;
    logic         stop_on_fail = 1'b0, start = 1'b0;
    logic         busy, done, fail_seen;
    logic [3:0]   dut_valid;
    logic [31:0]  dut_stim;
    logic [3:0]   dut_resp_valid = '0;
    logic [127:0] dut_resp = '0;
    logic [4:0]   pass_count, fail_count, first_fail_idx;

    unit_test_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr), .load_chan(load_chan),
        .load_stim(load_stim), .load_exp(load_exp), .num_vec(num_vec), .stop_on_fail(stop_on_fail),
        .start(start), .busy(busy), .done(done), .dut_valid(dut_valid), .dut_stim(dut_stim),
        .dut_resp_valid(dut_resp_valid), .dut_resp(dut_resp), .pass_count(pass_count),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx), .fail_seen(fail_seen)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [3:0] mask; logic [31:0] stim; } iss_t;
    typedef struct { logic [4:0] p; logic [4:0] f; } res_t;
    typedef struct { logic [1:0] chan; logic [31:0] stim; logic [31:0] exp; bit want_pass; } vec_rec_t;

    iss_t     iss_q[$];
    res_t     res_q[$];
    vec_rec_t vt[DEPTH];
    logic [1:0]  m_chan[DEPTH];
    logic [31:0] m_stim[DEPTH];
    bit          m_pass[DEPTH];
    int          lat[4] = '{1, 1, 1, 1};
    bit          en[4]  = '{1, 1, 1, 1};
    int          cnt[4] = '{0, 0, 0, 0};
    logic [31:0] sv[4];
    bit          spur0 = 1'b0;
    logic [4:0]  pp = '0, pf = '0;
    int          n_chk = 0, n_fail = 0;

    // Behavioural DUTs: echo the stimulus lat[c] cycles after the strobe; en[c]=0 models a silent DUT.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            dut_resp_valid[c] = 1'b0;
            if (cnt[c] > 0) begin
                cnt[c] = cnt[c] - 1;
                if (cnt[c] == 0) begin
                    dut_resp_valid[c] = 1'b1;
                    dut_resp[c*32 +: 32] = sv[c];
                end
            end
            if (dut_valid[c] && en[c]) begin
                cnt[c] = lat[c];
                sv[c]  = dut_stim;
            end
        end
        if (spur0) begin
            dut_resp_valid[0] = 1'b1;
            dut_resp[31:0]    = 32'hdead_beef;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [1:0] ch, input logic [31:0] s, input logic [31:0] e, input bit want);
        load_we = 1'b1; load_addr = 5'(a); load_chan = ch; load_stim = s; load_exp = e;
        @(negedge clk);
        load_we = 1'b0;
        m_chan[a] = ch; m_stim[a] = s; m_pass[a] = want;
    endtask

    // Model of a run: expected strobes, counter steps and the cycle in which done appears.
    task automatic plan(input int nv, input bit sof, output int edc, output logic [4:0] ep,
                        output logic [4:0] ef, output logic [4:0] effi, output bit eseen);
        int n;
        iss_t it;
        res_t r;
        n = (nv > DEPTH) ? DEPTH : nv;
        edc = 1; ep = '0; ef = '0; effi = '0; eseen = 1'b0;
        for (int i = 0; i < n; i++) begin
            it.mask = 4'b0001 << m_chan[i];
            it.stim = m_stim[i];
            iss_q.push_back(it);
            edc += 2 + (en[m_chan[i]] ? lat[m_chan[i]] : TIMEOUT);
            if (m_pass[i]) ep = ep + 5'd1;
            else begin
                ef = ef + 5'd1;
                if (!eseen) begin eseen = 1'b1; effi = 5'(i); end
            end
            r.p = ep; r.f = ef;
            res_q.push_back(r);
            if (!m_pass[i] && sof) break;
        end
    endtask

    task automatic sample();
        iss_t it;
        res_t r;
        if (dut_valid != '0) begin
            if (iss_q.size() == 0) chk("stray_strobe", 64'(dut_valid), 64'd0);
            else begin
                it = iss_q.pop_front();
                chk("strobe", 64'(dut_valid), 64'(it.mask));
                chk("stim", 64'(dut_stim), 64'(it.stim));
            end
        end
        if ((pass_count != pp || fail_count != pf) && (pass_count != '0 || fail_count != '0)) begin
            if (res_q.size() == 0) chk("stray_count", 64'({pass_count, fail_count}), 64'd0);
            else begin
                r = res_q.pop_front();
                chk("counts", 64'({pass_count, fail_count}), 64'({r.p, r.f}));
            end
        end
        pp = pass_count; pf = fail_count;
    endtask

    task automatic go(input int nv, input bit sof);
        pp = pass_count; pf = fail_count;
        num_vec = 5'(nv); stop_on_fail = sof; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic watch(input int budget, output int dc);
        dc = -1;
        for (int c = 1; c <= budget; c++) begin
            sample();
            if (done) begin dc = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic run(input string nm, input int nv, input bit sof);
        int edc, dc;
        logic [4:0] ep, ef, effi;
        bit eseen;
        plan(nv, sof, edc, ep, ef, effi, eseen);
        go(nv, sof);
        watch(edc + 20, dc);
        chk({nm, "_done_cycle"}, 64'(dc), 64'(edc));
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({nm, "_pass"}, 64'(pass_count), 64'(ep));
        chk({nm, "_fail"}, 64'(fail_count), 64'(ef));
        chk({nm, "_ffi"}, 64'(first_fail_idx), 64'(effi));
        chk({nm, "_seen"}, 64'(fail_seen), 64'(eseen));
        chk({nm, "_idle"}, 64'({busy, done}), 64'd0);
        chk({nm, "_sb_empty"}, 64'(iss_q.size() + res_q.size()), 64'd0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_dut_valid"}, 64'(dut_valid), 64'd0);
        chk({nm, "_dut_stim"}, 64'(dut_stim), 64'd0);
        chk({nm, "_pass"}, 64'(pass_count), 64'd0);
        chk({nm, "_fail"}, 64'(fail_count), 64'd0);
        chk({nm, "_ffi"}, 64'(first_fail_idx), 64'd0);
        chk({nm, "_seen"}, 64'(fail_seen), 64'd0);
    endtask

    initial begin
        int dc, edc;
        logic [4:0] ep, ef, effi;
        bit eseen;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        load(0, 2'd0, 32'd5, 32'd5, 1'b1);
        load(1, 2'd1, 32'd7, 32'd9, 1'b0);
        load(2, 2'd2, 32'd3, 32'd3, 1'b1);
        run("tp_nostop", 3, 1'b0);
        run("tp_stop", 3, 1'b1);

        for (int i = 0; i < DEPTH; i++) begin
            vt[i].chan      = 2'(i % 4);
            vt[i].stim      = $urandom();
            vt[i].want_pass = (i % 5) != 3;
            vt[i].exp       = vt[i].want_pass ? vt[i].stim : vt[i].stim ^ 32'h0000_0100;
        end
        for (int i = 0; i < DEPTH; i++) load(i, vt[i].chan, vt[i].stim, vt[i].exp, vt[i].want_pass);
        run("tbl_clamp", 31, 1'b0);
        run("tbl_stop", 23, 1'b1);
        run("tbl_one", 1, 1'b0);

        // Slow DUT on ch3 with a stray ch0 strobe during its WAIT.
        lat[3] = 5;
        load(0, 2'd3, 32'h1234_5678, 32'h1234_5678, 1'b1);
        fork
            run("slow_ch3", 1, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 spur0 = 1'b1;
                @(posedge clk);
                #1 spur0 = 1'b0;
            end
        join
        lat[3] = 1;

`ifdef UNIT_TEST_SEQ_TIMEOUT_EN
        en[1] = 1'b0;
        load(0, 2'd1, 32'h11, 32'h11, 1'b0);
        load(1, 2'd0, 32'h22, 32'h22, 1'b1);
        run("timeout", 2, 1'b0);
        en[1] = 1'b1;
`endif

        // Reset while vector 2 is in WAIT.
        load(0, 2'd0, 32'd5, 32'd5, 1'b1);
        load(1, 2'd1, 32'd7, 32'd9, 1'b0);
        load(2, 2'd2, 32'd3, 32'd3, 1'b1);
        plan(3, 1'b0, edc, ep, ef, effi, eseen);
        go(3, 1'b0);
        watch(7, dc);
        chk("midrun_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        iss_q.delete(); res_q.delete();
        pp = '0; pf = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("after_reset", 1, 1'b0);

        run("zero_vec", 0, 1'b0);

        fork
            run("busy_load", 1, 1'b0);
            begin
                @(posedge clk);
                #1 load_we = 1'b1; load_addr = 5'd0; load_chan = 2'd1;
                load_stim = 32'h0bad_0bad; load_exp = 32'h0bad_0bad;
                repeat (3) @(posedge clk);
                #1 load_we = 1'b0;
            end
        join
        run("busy_load_after", 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
